// File: rtl/button_debounce.sv
// button_debounce: two-flop synchroniser followed by a stability-qualifying
// FSM. A new button level is accepted only after an unbroken run of
// DEBOUNCE_CYCLES cycles. Outputs keep the board's active-low convention.
module button_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int COUNT_WIDTH     = 20
) (
  input  logic clock,
  input  logic reset,
  input  logic button_raw,
  output logic button_out,
  output logic settling
);

  typedef enum logic [1:0] {
    STABLE_HIGH = 2'b00,
    CHECK_LOW   = 2'b01,
    STABLE_LOW  = 2'b10,
    CHECK_HIGH  = 2'b11
  } state_t;

  // Truncated to the counter width; the legal parameter range keeps this exact.
  localparam logic [COUNT_WIDTH-1:0] COUNT_LAST = COUNT_WIDTH'(DEBOUNCE_CYCLES - 1);

  logic                   sync1_reg;
  logic                   sync2_reg;
  state_t                 state_reg;
  state_t                 state_next;
  logic [COUNT_WIDTH-1:0] count_reg;
  logic [COUNT_WIDTH-1:0] count_next;

  // Two-flop synchroniser; the idle level 1 is loaded on reset.
  always_ff @(posedge clock) begin
    if (!reset) begin
      sync1_reg <= 1'b1;
      sync2_reg <= 1'b1;
    end else begin
      sync1_reg <= button_raw;
      sync2_reg <= sync1_reg;
    end
  end

  // State and stability counter registers.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_reg <= STABLE_HIGH;
      count_reg <= '0;
    end else begin
      state_reg <= state_next;
      count_reg <= count_next;
    end
  end

  // Next-state logic: any bounce during a check falls back to the stable
  // state, so only an unbroken run of the new level is accepted.
  always_comb begin
    state_next = state_reg;
    count_next = '0;
    case (state_reg)
      STABLE_HIGH: begin
        if (!sync2_reg) state_next = CHECK_LOW;
      end
      CHECK_LOW: begin
        if (sync2_reg) begin
          state_next = STABLE_HIGH;
        end else if (count_reg == COUNT_LAST) begin
          state_next = STABLE_LOW;
        end else begin
          count_next = count_reg + COUNT_WIDTH'(1);
        end
      end
      STABLE_LOW: begin
        if (sync2_reg) state_next = CHECK_HIGH;
      end
      CHECK_HIGH: begin
        if (!sync2_reg) begin
          state_next = STABLE_LOW;
        end else if (count_reg == COUNT_LAST) begin
          state_next = STABLE_HIGH;
        end else begin
          count_next = count_reg + COUNT_WIDTH'(1);
        end
      end
      default: begin
        state_next = STABLE_HIGH;
        count_next = '0;
      end
    endcase
  end

  // Moore outputs decoded from the state alone, so the raw pin never glitches them.
  always_comb begin
    button_out = 1'b1;
    settling   = 1'b0;
    case (state_reg)
      STABLE_HIGH: begin
        button_out = 1'b1;
        settling   = 1'b0;
      end
      CHECK_LOW: begin
        button_out = 1'b1;
        settling   = 1'b1;
      end
      STABLE_LOW: begin
        button_out = 1'b0;
        settling   = 1'b0;
      end
      CHECK_HIGH: begin
        button_out = 1'b0;
        settling   = 1'b1;
      end
      default: begin
        button_out = 1'b1;
        settling   = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_button_debounce.sv
// Directed bench for button_debounce with DEBOUNCE_CYCLES = 4. Each step
// drives one cycle of inputs, pushes the expected outputs to a scoreboard,
// and pops/compares them one time unit after the following rising edge.
module tb_button_debounce;

  localparam int DC = 4;
  localparam int CW = 4;

  logic clock;
  logic reset;
  logic button_raw;
  logic button_out;
  logic settling;

  typedef struct {
    string tag;
    logic  exp_out;
    logic  exp_settle;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks;
  int   n_fail;
  int   step_no;

  button_debounce #(
    .DEBOUNCE_CYCLES(DC),
    .COUNT_WIDTH    (CW)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .button_raw(button_raw),
    .button_out(button_out),
    .settling  (settling)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Drive n cycles; patterns are MSB-first (bit n-1 is the first cycle).
  task automatic seq(input logic rst_n, input logic [15:0] raw_pat,
                     input logic [15:0] out_pat, input logic [15:0] set_pat,
                     input int n, input string tag);
    exp_t e;
    exp_t got;
    for (int i = 0; i < n; i++) begin
      reset      = rst_n;
      button_raw = raw_pat[n-1-i];
      e.tag        = $sformatf("%s[%0d]", tag, i + 1);
      e.exp_out    = out_pat[n-1-i];
      e.exp_settle = set_pat[n-1-i];
      exp_q.push_back(e);
      @(posedge clock);
      #1;
      step_no++;
      n_checks++;
      assert (exp_q.size() > 0) else begin
        n_fail++;
        $error("FAIL %s scoreboard empty: observed 0 entries, expected 1", tag);
      end
      if (exp_q.size() > 0) begin
        got = exp_q.pop_front();
        n_checks++;
        assert (button_out === got.exp_out) else begin
          n_fail++;
          $error("FAIL %s button_out: observed %b expected %b", got.tag, button_out, got.exp_out);
        end
        n_checks++;
        assert (settling === got.exp_settle) else begin
          n_fail++;
          $error("FAIL %s settling: observed %b expected %b", got.tag, settling, got.exp_settle);
        end
        $display("step %0d %s reset=%b raw=%b -> button_out=%b settling=%b",
                 step_no, got.tag, rst_n, raw_pat[n-1-i], button_out, settling);
      end
    end
  endtask

  initial begin
    n_checks   = 0;
    n_fail     = 0;
    step_no    = 0;
    reset      = 1'b0;
    button_raw = 1'b1;

    // Reset held three cycles, then released with the button idle.
    seq(1'b0, 16'b111, 16'b111, 16'b000, 3, "reset_hold");
    seq(1'b1, 16'b111, 16'b111, 16'b000, 3, "reset_idle");

    // Clean press: checking from E3, output falls after E7 (not E6).
    seq(1'b1, 16'b000000000, 16'b111111000, 16'b001111000, 9, "clean_press");

    // Release from STABLE_LOW: mirror timing.
    seq(1'b1, 16'b111111111, 16'b000000111, 16'b001111000, 9, "release1");

    // Bounce rejection: 0,0,1,0,0 then 1 held; output never changes.
    seq(1'b1, 16'b00100111111, 16'b11111111111, 16'b00110110000, 11, "bounce_rej");

    // Bounce then settle: 0,1,0,1 then 0 held; accepted 6 cycles after
    // the last falling edge is sampled (E5 -> E11).
    seq(1'b1, 16'b01010000000, 16'b11111111110, 16'b00101011110, 11, "bounce_settle");

    // Release again back to STABLE_HIGH.
    seq(1'b1, 16'b111111111, 16'b000000111, 16'b001111000, 9, "release2");

    // Reset mid-qualification: enter CHECK_LOW, reach count 2, reset one cycle.
    seq(1'b1, 16'b00000, 16'b11111, 16'b00111, 5, "midq_enter");
    seq(1'b0, 16'b0, 16'b1, 16'b0, 1, "midq_reset");
    // After release the full DC+2 latency elapses again (E7 -> E13).
    seq(1'b1, 16'b00000000, 16'b11111100, 16'b00111100, 8, "midq_after");

    n_checks++;
    assert (exp_q.size() == 0) else begin
      n_fail++;
      $error("FAIL scoreboard_drain: observed %0d leftover, expected 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
